// File: rtl/mem_lsu.sv
// Multi-cycle load/store unit for the MEM slot: ce/ack data bus, LL/SC link bit,
// alignment exceptions and bus timeout, with a registered write-back result.
module mem_lsu #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter bit          BIG_ENDIAN = 1'b1,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid_i,
   input  logic [7:0]          aluop_i,
   input  logic [4:0]          wd_i,
   input  logic                wreg_i,
   input  logic [31:0]         wdata_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [31:0]         reg2_i,
   input  logic                flush_i,
   input  logic                mem_ack_i,
   input  logic [DATA_W-1:0]   mem_data_i,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_sel_o,
   output logic [DATA_W-1:0]   mem_data_o,
   output logic                mem_ce_o,
   output logic                stall_o,
   output logic                valid_o,
   output logic [4:0]          wd_o,
   output logic                wreg_o,
   output logic [31:0]         wdata_o,
   output logic                excp_adel_o,
   output logic                excp_ades_o,
   output logic                bus_err_o,
   output logic                llbit_o
);
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned NH    = NB / 2;
   localparam int unsigned NW    = NB / 4;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam int unsigned CNT_W = 16;
   localparam int unsigned LA_W  = ADDR_W - 2;

   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LL  = 8'hF0;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;
   localparam logic [7:0] OP_SC  = 8'hF8;

   typedef enum logic [0:0] {S_IDLE, S_ACCESS} state_t;

   state_t             r_state;
   logic [7:0]         r_op;
   logic [OFF_W-1:0]   r_shift;
   logic               r_wreg;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_llbit;
   logic [LA_W-1:0]    r_link;

   logic               w_is_mem;
   logic               w_is_load;
   logic [1:0]         w_size;
   logic               w_misal;
   logic               w_sc_ok;
   logic               w_go;
   logic [OFF_W-1:0]   w_k;
   logic [OFF_W-1:0]   w_shift;
   logic [NB-1:0]      w_sel;
   logic [DATA_W-1:0]  w_wdata;
   logic [31:0]        w_rd;
   logic [31:0]        w_ld;
   logic [CNT_W-1:0]   w_cnt_nxt;

   // Op decode: size 0=byte, 1=half, 2=word
   always_comb begin
      w_is_mem  = 1'b1;
      w_is_load = 1'b1;
      w_size    = 2'd0;
      case (aluop_i)
         OP_LB, OP_LBU: w_size = 2'd0;
         OP_LH, OP_LHU: w_size = 2'd1;
         OP_LW, OP_LL:  w_size = 2'd2;
         OP_SB:         w_is_load = 1'b0;
         OP_SH:         begin w_is_load = 1'b0; w_size = 2'd1; end
         OP_SW, OP_SC:  begin w_is_load = 1'b0; w_size = 2'd2; end
         default:       begin w_is_mem = 1'b0; w_is_load = 1'b0; end
      endcase
   end

   // Lane selection: w_shift is the lowest lane index touched by the access
   always_comb begin
      w_k     = addr_i[OFF_W-1:0];
      w_shift = w_k;
      if (BIG_ENDIAN) begin
         case (w_size)
            2'd0:    w_shift = OFF_W'(NB - 1) - w_k;
            2'd1:    w_shift = OFF_W'(NB - 2) - w_k;
            default: w_shift = OFF_W'(NB - 4) - w_k;
         endcase
      end
      case (w_size)
         2'd0:    begin w_sel = NB'(1)  << w_shift; w_wdata = {NB{reg2_i[7:0]}};  end
         2'd1:    begin w_sel = NB'(3)  << w_shift; w_wdata = {NH{reg2_i[15:0]}}; end
         default: begin w_sel = NB'(15) << w_shift; w_wdata = {NW{reg2_i}};       end
      endcase
   end

   assign w_misal = ((w_size == 2'd1) && addr_i[0]) ||
                    ((w_size == 2'd2) && (addr_i[1:0] != 2'b00));
   assign w_sc_ok = r_llbit && (addr_i[ADDR_W-1:2] == r_link);
   assign w_go    = (r_state == S_IDLE) && req_valid_i && !flush_i && w_is_mem &&
                    !w_misal && ((aluop_i != OP_SC) || w_sc_ok);
   assign stall_o = (r_state == S_ACCESS) || w_go;
   assign llbit_o = r_llbit;
   assign w_cnt_nxt = r_cnt + CNT_W'(1);

   // Load extraction from the lanes latched at accept
   always_comb begin
      w_rd = 32'(mem_data_i >> {r_shift, 3'b000});
      case (r_op)
         OP_LB:   w_ld = {{24{w_rd[7]}}, w_rd[7:0]};
         OP_LBU:  w_ld = {24'd0, w_rd[7:0]};
         OP_LH:   w_ld = {{16{w_rd[15]}}, w_rd[15:0]};
         OP_LHU:  w_ld = {16'd0, w_rd[15:0]};
         default: w_ld = w_rd;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_op        <= 8'd0;
         r_shift     <= '0;
         r_wreg      <= 1'b0;
         r_cnt       <= '0;
         r_llbit     <= 1'b0;
         r_link      <= '0;
         mem_addr_o  <= '0;
         mem_we_o    <= 1'b0;
         mem_sel_o   <= '0;
         mem_data_o  <= '0;
         mem_ce_o    <= 1'b0;
         valid_o     <= 1'b0;
         wd_o        <= 5'd0;
         wreg_o      <= 1'b0;
         wdata_o     <= 32'd0;
         excp_adel_o <= 1'b0;
         excp_ades_o <= 1'b0;
         bus_err_o   <= 1'b0;
      end else begin
         valid_o     <= 1'b0;
         excp_adel_o <= 1'b0;
         excp_ades_o <= 1'b0;
         bus_err_o   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid_i && !flush_i) begin
                  wd_o <= wd_i;
                  if (!w_is_mem) begin
                     valid_o <= 1'b1;
                     wreg_o  <= wreg_i;
                     wdata_o <= wdata_i;
                  end else if (w_misal) begin
                     valid_o     <= 1'b1;
                     wreg_o      <= 1'b0;
                     wdata_o     <= 32'd0;
                     excp_adel_o <= w_is_load;
                     excp_ades_o <= !w_is_load;
                  end else if ((aluop_i == OP_SC) && !w_sc_ok) begin
                     valid_o <= 1'b1;
                     wreg_o  <= wreg_i;
                     wdata_o <= 32'd0;
                  end else begin
                     mem_ce_o   <= 1'b1;
                     mem_we_o   <= !w_is_load;
                     mem_sel_o  <= w_sel;
                     mem_data_o <= w_wdata;
                     mem_addr_o <= addr_i;
                     r_op       <= aluop_i;
                     r_shift    <= w_shift;
                     r_wreg     <= wreg_i;
                     r_cnt      <= '0;
                     r_state    <= S_ACCESS;
                  end
               end
            end
            default: begin
               if (flush_i || mem_ack_i || (w_cnt_nxt == CNT_W'(TIMEOUT))) begin
                  mem_ce_o  <= 1'b0;
                  mem_we_o  <= 1'b0;
                  mem_sel_o <= '0;
                  r_state   <= S_IDLE;
               end
               if (flush_i) begin
                  r_cnt <= '0;
               end else if (mem_ack_i) begin
                  valid_o <= 1'b1;
                  wreg_o  <= r_wreg;
                  wdata_o <= !mem_we_o ? w_ld : ((r_op == OP_SC) ? 32'd1 : 32'd0);
                  if (r_op == OP_LL) begin
                     r_llbit <= 1'b1;
                     r_link  <= mem_addr_o[ADDR_W-1:2];
                  end else if (mem_we_o && (mem_addr_o[ADDR_W-1:2] == r_link)) begin
                     r_llbit <= 1'b0;
                  end
               end else begin
                  r_cnt <= w_cnt_nxt;
                  if (w_cnt_nxt == CNT_W'(TIMEOUT)) begin
                     valid_o   <= 1'b1;
                     bus_err_o <= 1'b1;
                     wreg_o    <= 1'b0;
                     wdata_o   <= 32'd0;
                  end
               end
            end
         endcase
         // A flush always breaks the link, overriding any LL completing this cycle
         if (flush_i) r_llbit <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 32-bit big-endian and a 64-bit little-endian
// instance, write-back results checked against a scoreboard of expectations.
module tb_mem_lsu;
   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LL  = 8'hF0;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;
   localparam logic [7:0] OP_SC  = 8'hF8;
   localparam logic [7:0] OP_OR  = 8'h25;

   typedef struct packed {
      logic        wreg;
      logic [31:0] wdata;
      logic [4:0]  wd;
      logic [2:0]  exc;   // {adel, ades, bus_err}
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  aluop = 8'd0;
   logic [4:0]  wd = 5'd0;
   logic        wreg = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] reg2 = 32'd0;
   logic        flush = 1'b0;

   logic        a_req = 1'b0, a_ack = 1'b0;
   logic [31:0] a_rdata = 32'd0;
   logic [31:0] a_addr, a_wdat, a_wdata;
   logic [3:0]  a_sel;
   logic [4:0]  a_wd;
   logic        a_we, a_ce, a_stall, a_valid, a_wreg, a_adel, a_ades, a_berr, a_llbit;

   logic        b_req = 1'b0, b_ack = 1'b0;
   logic [63:0] b_rdata = 64'd0;
   logic [31:0] b_addr, b_wdata;
   logic [63:0] b_wdat;
   logic [7:0]  b_sel;
   logic [4:0]  b_wd;
   logic        b_we, b_ce, b_stall, b_valid, b_wreg, b_adel, b_ades, b_berr, b_llbit;

   int total = 0;
   int bad   = 0;
   exp_t  qa[$], qb[$];
   string qa_tag[$], qb_tag[$];

   always #5 clk = ~clk;

   mem_lsu #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(8)) u_a (
      .clk(clk), .rst(rst), .req_valid_i(a_req), .aluop_i(aluop), .wd_i(wd), .wreg_i(wreg),
      .wdata_i(wdata), .addr_i(addr), .reg2_i(reg2), .flush_i(flush), .mem_ack_i(a_ack),
      .mem_data_i(a_rdata), .mem_addr_o(a_addr), .mem_we_o(a_we), .mem_sel_o(a_sel),
      .mem_data_o(a_wdat), .mem_ce_o(a_ce), .stall_o(a_stall), .valid_o(a_valid), .wd_o(a_wd),
      .wreg_o(a_wreg), .wdata_o(a_wdata), .excp_adel_o(a_adel), .excp_ades_o(a_ades),
      .bus_err_o(a_berr), .llbit_o(a_llbit));

   mem_lsu #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(4)) u_b (
      .clk(clk), .rst(rst), .req_valid_i(b_req), .aluop_i(aluop), .wd_i(wd), .wreg_i(wreg),
      .wdata_i(wdata), .addr_i(addr), .reg2_i(reg2), .flush_i(flush), .mem_ack_i(b_ack),
      .mem_data_i(b_rdata), .mem_addr_o(b_addr), .mem_we_o(b_we), .mem_sel_o(b_sel),
      .mem_data_o(b_wdat), .mem_ce_o(b_ce), .stall_o(b_stall), .valid_o(b_valid), .wd_o(b_wd),
      .wreg_o(b_wreg), .wdata_o(b_wdata), .excp_adel_o(b_adel), .excp_ades_o(b_ades),
      .bus_err_o(b_berr), .llbit_o(b_llbit));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic exp_t mk(input logic wr, input logic [31:0] d, input logic [4:0] r,
                               input logic [2:0] e);
      exp_t x;
      x.wreg = wr; x.wdata = d; x.wd = r; x.exc = e;
      return x;
   endfunction

   task automatic expect_res(input bit ub, input string tg, input exp_t e);
      if (ub) begin qb.push_back(e); qb_tag.push_back(tg); end
      else    begin qa.push_back(e); qa_tag.push_back(tg); end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard pop on every write-back pulse
   always @(negedge clk) begin : mon_a
      exp_t  e;
      string t;
      if (rst && a_valid) begin
         chk("a_result_pending", 64'(qa.size() != 0), 64'd1);
         if (qa.size() != 0) begin
            e = qa.pop_front();
            t = qa_tag.pop_front();
            chk(t, 64'({a_wreg, a_wdata, a_wd, a_adel, a_ades, a_berr}), 64'(e));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t  e;
      string t;
      if (rst && b_valid) begin
         chk("b_result_pending", 64'(qb.size() != 0), 64'd1);
         if (qb.size() != 0) begin
            e = qb.pop_front();
            t = qb_tag.pop_front();
            chk(t, 64'({b_wreg, b_wdata, b_wd, b_adel, b_ades, b_berr}), 64'(e));
         end
      end
   end

   // Bus op: accept, hold for `waits` cycles without ack, then ack with rdat
   task automatic bus_op(input bit ub, input string tg, input logic [7:0] op,
                         input logic [31:0] ad, input logic [31:0] r2, input logic [4:0] d,
                         input logic wr, input int waits, input logic [63:0] rdat,
                         input logic [7:0] esel, input logic ewe, input logic [63:0] edat);
      aluop = op; addr = ad; reg2 = r2; wd = d; wreg = wr;
      if (ub) b_req = 1'b1; else a_req = 1'b1;
      @(negedge clk);
      chk({tg, "_stall_accept"}, 64'(ub ? b_stall : a_stall), 64'd1);
      cyc();
      a_req = 1'b0; b_req = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            if (ub) b_ack = 1'b1; else a_ack = 1'b1;
            a_rdata = 32'(rdat);
            b_rdata = rdat;
         end
         @(negedge clk);
         chk({tg, "_ce"},    64'(ub ? b_ce : a_ce), 64'd1);
         chk({tg, "_stall"}, 64'(ub ? b_stall : a_stall), 64'd1);
         chk({tg, "_sel"},   ub ? 64'(b_sel) : 64'(a_sel), 64'(esel));
         chk({tg, "_addr"},  64'(ub ? b_addr : a_addr), 64'(ad));
         chk({tg, "_we"},    64'(ub ? b_we : a_we), 64'(ewe));
         if (ewe) chk({tg, "_wdat"}, ub ? b_wdat : 64'(a_wdat), edat);
         cyc();
      end
      a_ack = 1'b0; b_ack = 1'b0;
   endtask

   // Single-cycle op (pass-through, misaligned, failed SC): no stall, no bus access
   task automatic imm_op(input bit ub, input string tg, input logic [7:0] op,
                         input logic [31:0] ad, input logic [31:0] r2, input logic [4:0] d,
                         input logic wr, input logic [31:0] wdin);
      aluop = op; addr = ad; reg2 = r2; wd = d; wreg = wr; wdata = wdin;
      if (ub) b_req = 1'b1; else a_req = 1'b1;
      @(negedge clk);
      chk({tg, "_stall"}, 64'(ub ? b_stall : a_stall), 64'd0);
      cyc();
      a_req = 1'b0; b_req = 1'b0;
      @(negedge clk);
      chk({tg, "_no_ce"}, 64'(ub ? b_ce : a_ce), 64'd0);
      cyc();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_bus",  64'({a_ce, a_we, a_sel, a_addr}), 64'd0);
      chk("rst_a_wdat", 64'(a_wdat), 64'd0);
      chk("rst_a_wb",   64'({a_valid, a_wreg, a_wdata, a_wd, a_adel, a_ades, a_berr, a_llbit}), 64'd0);
      chk("rst_a_stall", 64'(a_stall), 64'd0);
      chk("rst_b_bus",  64'({b_ce, b_we, b_sel, b_addr}), 64'd0);
      chk("rst_b_wdat", b_wdat, 64'd0);
      chk("rst_b_wb",   64'({b_valid, b_wreg, b_wdata, b_wd, b_adel, b_ades, b_berr, b_llbit}), 64'd0);
      rst = 1'b1;
      cyc();

      // LB big-endian offset 3 -> lane 0, sign-extended, 3 wait states
      expect_res(0, "a_lb", mk(1'b1, 32'hFFFF_FFF4, 5'd3, 3'b000));
      bus_op(0, "a_lb", OP_LB, 32'h103, 32'd0, 5'd3, 1'b1, 3, 64'h1122_33F4, 8'h01, 1'b0, 64'd0);
      @(negedge clk);
      chk("a_lb_stall_after", 64'(a_stall), 64'd0);
      chk("a_lb_ce_after", 64'(a_ce), 64'd0);
      cyc();

      // LH big-endian offset 2 -> lanes 1:0
      expect_res(0, "a_lh", mk(1'b1, 32'hFFFF_8001, 5'd4, 3'b000));
      bus_op(0, "a_lh", OP_LH, 32'h102, 32'd0, 5'd4, 1'b1, 0, 64'h1111_8001, 8'h03, 1'b0, 64'd0);

      // SH little-endian 64-bit offset 6 -> lanes 7:6, replicated data
      expect_res(1, "b_sh", mk(1'b0, 32'd0, 5'd2, 3'b000));
      bus_op(1, "b_sh", OP_SH, 32'h16, 32'h0000_ABCD, 5'd2, 1'b0, 0, 64'd0, 8'hC0, 1'b1,
             64'hABCD_ABCD_ABCD_ABCD);
      expect_res(1, "b_lhu", mk(1'b1, 32'h0000_1234, 5'd5, 3'b000));
      bus_op(1, "b_lhu", OP_LHU, 32'h16, 32'd0, 5'd5, 1'b1, 1, 64'h1234_5678_9ABC_DEF0,
             8'hC0, 1'b0, 64'd0);
      expect_res(1, "b_lb", mk(1'b1, 32'hFFFF_FF9A, 5'd6, 3'b000));
      bus_op(1, "b_lb", OP_LB, 32'h3, 32'd0, 5'd6, 1'b1, 0, 64'h1234_5678_9ABC_DEF0,
             8'h08, 1'b0, 64'd0);
      expect_res(1, "b_lbu", mk(1'b1, 32'h0000_0056, 5'd6, 3'b000));
      bus_op(1, "b_lbu", OP_LBU, 32'h5, 32'd0, 5'd6, 1'b1, 0, 64'h1234_5678_9ABC_DEF0,
             8'h20, 1'b0, 64'd0);
      expect_res(1, "b_pass", mk(1'b1, 32'hDEAD_BEEF, 5'd7, 3'b000));
      imm_op(1, "b_pass", OP_OR, 32'h0, 32'd0, 5'd7, 1'b1, 32'hDEAD_BEEF);

      // LL, intervening SW to the link word, then SC fails without a bus access
      expect_res(0, "a_ll200", mk(1'b1, 32'h1234_5678, 5'd8, 3'b000));
      bus_op(0, "a_ll200", OP_LL, 32'h200, 32'd0, 5'd8, 1'b1, 0, 64'h1234_5678, 8'h0F, 1'b0, 64'd0);
      @(negedge clk);
      chk("a_ll200_llbit", 64'(a_llbit), 64'd1);
      cyc();
      expect_res(0, "a_sw200", mk(1'b0, 32'd0, 5'd0, 3'b000));
      bus_op(0, "a_sw200", OP_SW, 32'h200, 32'h99, 5'd0, 1'b0, 0, 64'd0, 8'h0F, 1'b1, 64'h99);
      @(negedge clk);
      chk("a_sw200_llbit", 64'(a_llbit), 64'd0);
      cyc();
      expect_res(0, "a_sc_fail", mk(1'b1, 32'd0, 5'd9, 3'b000));
      imm_op(0, "a_sc_fail", OP_SC, 32'h200, 32'h7, 5'd9, 1'b1, 32'd0);

      // LL then successful SC
      expect_res(0, "a_ll40", mk(1'b1, 32'h0000_CAFE, 5'd10, 3'b000));
      bus_op(0, "a_ll40", OP_LL, 32'h40, 32'd0, 5'd10, 1'b1, 0, 64'h0000_CAFE, 8'h0F, 1'b0, 64'd0);
      expect_res(0, "a_sc_ok", mk(1'b1, 32'd1, 5'd11, 3'b000));
      bus_op(0, "a_sc_ok", OP_SC, 32'h40, 32'd5, 5'd11, 1'b1, 1, 64'd0, 8'h0F, 1'b1, 64'd5);
      @(negedge clk);
      chk("a_sc_ok_llbit", 64'(a_llbit), 64'd0);
      cyc();

      // Misaligned load and store
      expect_res(0, "a_lw_mis", mk(1'b0, 32'd0, 5'd12, 3'b100));
      imm_op(0, "a_lw_mis", OP_LW, 32'h102, 32'd0, 5'd12, 1'b1, 32'd0);
      expect_res(1, "b_sh_mis", mk(1'b0, 32'd0, 5'd13, 3'b010));
      imm_op(1, "b_sh_mis", OP_SH, 32'h101, 32'h55, 5'd13, 1'b0, 32'd0);

      // SW with no ack on TIMEOUT=4 instance
      expect_res(1, "b_timeout", mk(1'b0, 32'd0, 5'd14, 3'b001));
      aluop = OP_SW; addr = 32'h8; reg2 = 32'h55; wd = 5'd14; wreg = 1'b0; b_req = 1'b1;
      @(negedge clk);
      chk("b_to_stall_accept", 64'(b_stall), 64'd1);
      cyc();
      b_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b_to_ce_held", 64'(b_ce), 64'd1);
         cyc();
      end
      @(negedge clk);
      chk("b_to_ce_drop", 64'(b_ce), 64'd0);
      chk("b_to_stall_drop", 64'(b_stall), 64'd0);
      cyc();

      // Flush coinciding with ack during a load: no result, link cleared
      expect_res(0, "a_ll80", mk(1'b1, 32'h0000_AAAA, 5'd15, 3'b000));
      bus_op(0, "a_ll80", OP_LL, 32'h80, 32'd0, 5'd15, 1'b1, 0, 64'h0000_AAAA, 8'h0F, 1'b0, 64'd0);
      aluop = OP_LW; addr = 32'h84; wd = 5'd16; wreg = 1'b1; a_req = 1'b1;
      @(negedge clk);
      chk("a_fl_llbit_before", 64'(a_llbit), 64'd1);
      cyc();
      a_req = 1'b0; a_ack = 1'b1; flush = 1'b1; a_rdata = 32'h7777_7777;
      @(negedge clk);
      chk("a_fl_stall", 64'(a_stall), 64'd1);
      cyc();
      a_ack = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("a_fl_ce", 64'(a_ce), 64'd0);
      chk("a_fl_valid", 64'(a_valid), 64'd0);
      chk("a_fl_stall_after", 64'(a_stall), 64'd0);
      chk("a_fl_llbit", 64'(a_llbit), 64'd0);
      cyc();
      a_ack = 1'b1;
      cyc();
      a_ack = 1'b0;
      @(negedge clk);
      chk("a_late_ack_valid", 64'(a_valid), 64'd0);
      cyc();

      // Flush in IDLE discards the request
      aluop = OP_OR; wdata = 32'h1234; wd = 5'd17; wreg = 1'b1; b_req = 1'b1; flush = 1'b1;
      cyc();
      b_req = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("b_fl_idle_valid", 64'(b_valid), 64'd0);
      cyc();

      // Asynchronous reset mid-access
      aluop = OP_SW; addr = 32'h10; reg2 = 32'h1; wd = 5'd0; wreg = 1'b0; b_req = 1'b1;
      cyc();
      b_req = 1'b0;
      @(negedge clk);
      chk("b_rst_ce_before", 64'(b_ce), 64'd1);
      rst = 1'b0;
      #1;
      chk("b_rst_ce", 64'(b_ce), 64'd0);
      chk("b_rst_stall", 64'(b_stall), 64'd0);
      cyc();
      rst = 1'b1;
      cyc();

      chk("sb_drain_a", 64'(qa.size()), 64'd0);
      chk("sb_drain_b", 64'(qb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
